// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: two-port arbiter sharing one CPU-side bus between
// instruction fetch (port 0) and the memory stage (port 1).
// The grant is registered, and completed transactions return to IDLE for a
// cycle, so back-to-back transactions are never merged on the bus.
// ROUND_ROBIN = 0 means port 1 wins a tie. ROUND_ROBIN = 1 means the port not
// granted last wins a tie.
// Optional watchdog: define CPU_BUS_ARB_TIMEOUT_EN to add a TIMEOUT-cycle
// grant watchdog and the sticky o_timeout output.
// Handshake (all ports): the requester holds request/rw/address/wdata stable
// until the cycle where ready=1. On the following cycle it may drop request
// or present a new transaction.
module cpu_bus_arbiter #(
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int TIMEOUT     = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_p0_request,
    input  logic        i_p0_rw,
    input  logic [31:0] i_p0_address,
    input  logic [31:0] i_p0_wdata,
    output logic        o_p0_ready,
    output logic [31:0] o_p0_rdata,
    input  logic        i_p1_request,
    input  logic        i_p1_rw,
    input  logic [31:0] i_p1_address,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p1_ready,
    output logic [31:0] o_p1_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    output logic        o_timeout,
`endif
    output logic [1:0]  o_grant
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // 0 = port 0 granted last, 1 = port 1
    logic   expire;           // watchdog fires this cycle

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    logic [31:0] count_q, count_d;
    logic        timeout_q, timeout_d;

    // Watchdog count: cleared while idle, advances each grant cycle without ready.
    always_comb begin
        count_d   = count_q;
        timeout_d = timeout_q;
        expire    = 1'b0;
        if (state_q == IDLE) begin
            count_d = 32'd0;
        end else if (!i_bus_ready) begin
            count_d = count_q + 32'd1;
            if (count_q == 32'(TIMEOUT - 1)) begin
                expire    = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q   <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expire = 1'b0;
`endif

    // State and last-granted registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the grant until completion or watchdog.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_p0_request && i_p1_request) begin
                    if (ROUND_ROBIN) begin
                        state_d = last_q ? GRANT0 : GRANT1;
                    end else begin
                        state_d = GRANT1;
                    end
                end else if (i_p1_request) begin
                    state_d = GRANT1;
                end else if (i_p0_request) begin
                    state_d = GRANT0;
                end
            end
            GRANT0: begin
                if (i_bus_ready || expire) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GRANT1: begin
                if (i_bus_ready || expire) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and requester steering from the current owner.
    // A watchdog expiry completes the requester with a poison word and drops
    // the bus request. A real bus ready in the same cycle wins over the expiry.
    always_comb begin
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = 32'd0;
        o_bus_wdata   = 32'd0;
        o_p0_ready    = 1'b0;
        o_p0_rdata    = 32'd0;
        o_p1_ready    = 1'b0;
        o_p1_rdata    = 32'd0;
        case (state_q)
            GRANT0: begin
                o_bus_request = i_p0_request && !expire;
                o_bus_rw      = i_p0_rw;
                o_bus_address = i_p0_address;
                o_bus_wdata   = i_p0_wdata;
                o_p0_ready    = i_bus_ready || expire;
                o_p0_rdata    = expire ? 32'hDEADBEEF : i_bus_rdata;
            end
            GRANT1: begin
                o_bus_request = i_p1_request && !expire;
                o_bus_rw      = i_p1_rw;
                o_bus_address = i_p1_address;
                o_bus_wdata   = i_p1_wdata;
                o_p1_ready    = i_bus_ready || expire;
                o_p1_rdata    = expire ? 32'hDEADBEEF : i_bus_rdata;
            end
            default: ;
        endcase
    end

    assign o_grant = state_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter. Instance a uses fixed priority and
// instance b uses round-robin.
module tb_cpu_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Fixed-priority instance signals.
  logic        a_p0_req, a_p0_rw, a_p0_rdy, a_p1_req, a_p1_rw, a_p1_rdy;
  logic [31:0] a_p0_addr, a_p0_wd, a_p0_rd, a_p1_addr, a_p1_wd, a_p1_rd;
  logic        a_bus_req, a_bus_rw, a_bus_rdy;
  logic [31:0] a_bus_addr, a_bus_wd, a_bus_rd;
  logic [1:0]  a_grant;
  // Round-robin instance signals.
  logic        b_p0_req, b_p1_req, b_p0_rdy, b_p1_rdy;
  logic [31:0] b_p0_rd, b_p1_rd;
  logic        b_bus_req, b_bus_rw, b_bus_rdy;
  logic [31:0] b_bus_addr, b_bus_wd;
  logic [1:0]  b_grant;
`ifdef CPU_BUS_ARB_TIMEOUT_EN
  logic a_timeout, b_timeout;
`endif

  cpu_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(16)) dut_a (
    .i_clock(clk), .i_reset(rst),
    .i_p0_request(a_p0_req), .i_p0_rw(a_p0_rw), .i_p0_address(a_p0_addr),
    .i_p0_wdata(a_p0_wd), .o_p0_ready(a_p0_rdy), .o_p0_rdata(a_p0_rd),
    .i_p1_request(a_p1_req), .i_p1_rw(a_p1_rw), .i_p1_address(a_p1_addr),
    .i_p1_wdata(a_p1_wd), .o_p1_ready(a_p1_rdy), .o_p1_rdata(a_p1_rd),
    .o_bus_request(a_bus_req), .o_bus_rw(a_bus_rw), .o_bus_address(a_bus_addr),
    .o_bus_wdata(a_bus_wd), .i_bus_ready(a_bus_rdy), .i_bus_rdata(a_bus_rd),
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    .o_timeout(a_timeout),
`endif
    .o_grant(a_grant)
  );

  cpu_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(1024)) dut_b (
    .i_clock(clk), .i_reset(rst),
    .i_p0_request(b_p0_req), .i_p0_rw(1'b0), .i_p0_address(32'h0000_0A00),
    .i_p0_wdata(32'd0), .o_p0_ready(b_p0_rdy), .o_p0_rdata(b_p0_rd),
    .i_p1_request(b_p1_req), .i_p1_rw(1'b0), .i_p1_address(32'h0000_0B00),
    .i_p1_wdata(32'd0), .o_p1_ready(b_p1_rdy), .o_p1_rdata(b_p1_rd),
    .o_bus_request(b_bus_req), .o_bus_rw(b_bus_rw), .o_bus_address(b_bus_addr),
    .o_bus_wdata(b_bus_wd), .i_bus_ready(b_bus_rdy), .i_bus_rdata(32'h0000_00B5),
`ifdef CPU_BUS_ARB_TIMEOUT_EN
    .o_timeout(b_timeout),
`endif
    .o_grant(b_grant)
  );

  // A granted requester must keep request high until its completion.
  always @(negedge clk) begin
    if (!rst && a_grant == 2'b01) begin
      vectors++;
      assert (a_p0_req === 1'b1) else begin
        miscompares++;
        $error("FAIL proto_p0_drop observed=%b expected=1", a_p0_req);
      end
    end
    if (!rst && a_grant == 2'b10) begin
      vectors++;
      assert (a_p1_req === 1'b1) else begin
        miscompares++;
        $error("FAIL proto_p1_drop observed=%b expected=1", a_p1_req);
      end
    end
  end

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Give combinational outputs time to settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_a_p0(input logic req, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    a_p0_req = req; a_p0_rw = rw; a_p0_addr = addr; a_p0_wd = wd;
  endtask

  task automatic set_a_p1(input logic req, input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    a_p1_req = req; a_p1_rw = rw; a_p1_addr = addr; a_p1_wd = wd;
  endtask

  task automatic set_a_bus(input logic rdy, input logic [31:0] rd);
    a_bus_rdy = rdy; a_bus_rd = rd;
  endtask

  logic [1:0] exp_rr [6];

  initial begin
    exp_rr = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    rst = 1'b1;
    set_a_p0(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_p1(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);
    b_p0_req = 1'b0; b_p1_req = 1'b0; b_bus_rdy = 1'b0;
    tick(); tick();

    // Reset state.
    chk("rst_grant", 32'(a_grant), 32'd0);
    chk("rst_bus_req", 32'(a_bus_req), 32'd0);
    chk("rst_bus_addr", a_bus_addr, 32'd0);
    chk("rst_p0_ready", 32'(a_p0_rdy), 32'd0);
    chk("rst_p1_rdata", a_p1_rd, 32'd0);
    rst = 1'b0;
    tick();

    // Bus ready while idle is not forwarded.
    set_a_bus(1'b1, 32'hFFFF_0000);
    settle();
    chk("idle_rdy_p0", 32'(a_p0_rdy), 32'd0);
    chk("idle_rdy_p1", 32'(a_p1_rdy), 32'd0);
    tick();
    chk("idle_rdy_grant", 32'(a_grant), 32'd0);
    set_a_bus(1'b0, 32'd0);

    // Port 0 read of 0x100, bus ready on the third grant cycle.
    set_a_p0(1'b1, 1'b0, 32'h0000_0100, 32'd0);
    settle();
    chk("t1_idle_bus_req", 32'(a_bus_req), 32'd0);
    tick();
    chk("t1_grant", 32'(a_grant), 32'h1);
    chk("t1_bus_req", 32'(a_bus_req), 32'd1);
    chk("t1_bus_addr", a_bus_addr, 32'h0000_0100);
    chk("t1_bus_rw", 32'(a_bus_rw), 32'd0);
    chk("t1_p0_wait", 32'(a_p0_rdy), 32'd0);
    tick();
    tick();
    set_a_bus(1'b1, 32'h1234_5678);
    settle();
    chk("t1_p0_ready", 32'(a_p0_rdy), 32'd1);
    chk("t1_p0_rdata", a_p0_rd, 32'h1234_5678);
    chk("t1_p1_ready", 32'(a_p1_rdy), 32'd0);
    chk("t1_p1_rdata", a_p1_rd, 32'd0);
    tick();
    set_a_p0(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);
    settle();
    chk("t1_back_idle", 32'(a_grant), 32'd0);
    chk("t1_bus_req_low", 32'(a_bus_req), 32'd0);
    chk("t1_p0_ready_low", 32'(a_p0_rdy), 32'd0);

    // Simultaneous requests, fixed priority: port 1 first, then port 0.
    set_a_p0(1'b1, 1'b0, 32'h0000_0200, 32'd0);
    set_a_p1(1'b1, 1'b0, 32'h0000_0300, 32'd0);
    tick();
    chk("t2_grant_p1", 32'(a_grant), 32'h2);
    chk("t2_bus_addr_p1", a_bus_addr, 32'h0000_0300);
    set_a_bus(1'b1, 32'hAAAA_0001);
    settle();
    chk("t2_p1_ready", 32'(a_p1_rdy), 32'd1);
    chk("t2_p1_rdata", a_p1_rd, 32'hAAAA_0001);
    chk("t2_p0_ready", 32'(a_p0_rdy), 32'd0);
    chk("t2_p0_rdata", a_p0_rd, 32'd0);
    tick();
    set_a_p1(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);
    settle();
    chk("t2_gap_bus_req", 32'(a_bus_req), 32'd0);
    chk("t2_gap_grant", 32'(a_grant), 32'd0);
    tick();
    chk("t2_grant_p0", 32'(a_grant), 32'h1);
    chk("t2_bus_req_p0", 32'(a_bus_req), 32'd1);
    chk("t2_bus_addr_p0", a_bus_addr, 32'h0000_0200);
    set_a_bus(1'b1, 32'h0000_0055);
    settle();
    chk("t2_p0_ready", 32'(a_p0_rdy), 32'd1);
    chk("t2_p0_rdata_v", a_p0_rd, 32'h0000_0055);
    tick();
    set_a_p0(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);

    // Port 1 write with port 0 arriving mid-transaction.
    set_a_p1(1'b1, 1'b1, 32'h1000_0004, 32'hCAFE_F00D);
    tick();
    chk("t4_grant_p1", 32'(a_grant), 32'h2);
    set_a_p0(1'b1, 1'b0, 32'h0000_0400, 32'd0);
    settle();
    chk("t4_bus_rw", 32'(a_bus_rw), 32'd1);
    chk("t4_bus_addr", a_bus_addr, 32'h1000_0004);
    chk("t4_bus_wdata", a_bus_wd, 32'hCAFE_F00D);
    tick();
    chk("t4_hold_grant", 32'(a_grant), 32'h2);
    chk("t4_hold_addr", a_bus_addr, 32'h1000_0004);
    chk("t4_hold_wdata", a_bus_wd, 32'hCAFE_F00D);
    chk("t4_p0_wait", 32'(a_p0_rdy), 32'd0);
    tick();
    set_a_bus(1'b1, 32'd0);
    settle();
    chk("t4_p1_ready", 32'(a_p1_rdy), 32'd1);
    tick();
    set_a_p1(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);
    settle();
    chk("t4_gap_grant", 32'(a_grant), 32'd0);
    tick();
    chk("t4_grant_p0", 32'(a_grant), 32'h1);
    chk("t4_bus_addr_p0", a_bus_addr, 32'h0000_0400);
    chk("t4_bus_rw_p0", 32'(a_bus_rw), 32'd0);
    set_a_bus(1'b1, 32'h0000_0444);
    tick();
    set_a_p0(1'b0, 1'b0, 32'd0, 32'd0);
    set_a_bus(1'b0, 32'd0);

    // Reset during GRANT1 with no bus ready.
    set_a_p1(1'b1, 1'b0, 32'h0000_0500, 32'd0);
    tick();
    chk("t5_grant_p1", 32'(a_grant), 32'h2);
    chk("t5_bus_req", 32'(a_bus_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", 32'(a_grant), 32'd0);
    chk("t5_rst_bus_req", 32'(a_bus_req), 32'd0);
    chk("t5_rst_p1_ready", 32'(a_p1_rdy), 32'd0);
    set_a_p1(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b0;
    tick();

    // Round-robin: both ports request continuously for six transactions.
    b_p0_req = 1'b1;
    b_p1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_grant_%0d", i), 32'(b_grant), 32'(exp_rr[i]));
      b_bus_rdy = 1'b1;
      settle();
      chk($sformatf("rr_p1_ready_%0d", i), 32'(b_p1_rdy), 32'(exp_rr[i][1]));
      chk($sformatf("rr_p0_ready_%0d", i), 32'(b_p0_rdy), 32'(exp_rr[i][0]));
      tick();
      b_bus_rdy = 1'b0;
      settle();
      chk($sformatf("rr_gap_%0d", i), 32'(b_bus_req), 32'd0);
    end
    b_p0_req = 1'b0;
    b_p1_req = 1'b0;
    tick();

`ifdef CPU_BUS_ARB_TIMEOUT_EN
    // Watchdog: TIMEOUT=16, the bus never answers.
    chk("to_flag_clear", 32'(a_timeout), 32'd0);
    set_a_p0(1'b1, 1'b0, 32'h0000_0600, 32'd0);
    tick();
    chk("to_grant", 32'(a_grant), 32'h1);
    chk("to_wait_0", 32'(a_p0_rdy), 32'd0);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("to_wait_%0d", i), 32'(a_p0_rdy), 32'd0);
    end
    tick();
    chk("to_p0_ready", 32'(a_p0_rdy), 32'd1);
    chk("to_p0_rdata", a_p0_rd, 32'hDEAD_BEEF);
    chk("to_bus_req", 32'(a_bus_req), 32'd0);
    tick();
    set_a_p0(1'b0, 1'b0, 32'd0, 32'd0);
    chk("to_idle", 32'(a_grant), 32'd0);
    chk("to_flag_set", 32'(a_timeout), 32'd1);
    tick(); tick();
    chk("to_flag_sticky", 32'(a_timeout), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
